// File: rtl/intt_pkg.sv
// Shared constants, state/mode types and the pair address helpers
// for the time-multiplexed Kyber inverse NTT sequencer.
package intt_pkg;

  localparam int         N           = 256;
  localparam int         LOG_N       = 8;
  localparam int         Q           = 3329;
  localparam int         F           = 3303;
  localparam int         NUM_LAYERS  = 7;
  localparam logic [2:0] SCALE_LAYER = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic {
    MODE_BF    = 1'b0,
    MODE_SCALE = 1'b1
  } mode_e;

  // Distance between the two operands of a pair. The scale pass pairs
  // neighbours (2p, 2p+1), which behaves like a stride of 1.
  function automatic logic [7:0] pair_stride(input logic [2:0] layer);
    logic [7:0] stride;
    if (layer == SCALE_LAYER) begin
      stride = 8'd1;
    end else begin
      stride = 8'd2 << layer;
    end
    return stride;
  endfunction

  // Lower operand address: 2*len*g + o with g = p/len, o = p%len.
  // Since p = len*g + o this equals p + (p with the offset bits cleared).
  function automatic logic [7:0] pair_addr_a(input logic [6:0] p, input logic [2:0] layer);
    logic [7:0] pe;
    logic [7:0] mask;
    pe   = {1'b0, p};
    mask = pair_stride(layer) - 8'd1;
    return pe + (pe & ~mask);
  endfunction

endpackage

// File: rtl/intt_addr_gen.sv
// Pair/zeta/layer counters and registered issue addresses for one
// inverse NTT run. Outputs describe the pair issued in the current cycle.
module intt_addr_gen
  import intt_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic       step_i,
  input  logic       next_layer_i,
  input  logic       issue_next_i,
  output logic [6:0] p_o,
  output logic [2:0] layer_o,
  output logic [7:0] addr_a_o,
  output logic [7:0] addr_b_o,
  output logic [6:0] zeta_o,
  output logic       mode_o
);

  logic [6:0] p_q, p_d;
  logic [6:0] z_q, z_d;
  logic [2:0] layer_q, layer_d;
  logic [7:0] addr_a_q, addr_a_d;
  logic [7:0] addr_b_q, addr_b_d;
  logic [6:0] zeta_q, zeta_d;
  mode_e      mode_q, mode_d;
  logic [7:0] mask_s;
  logic       group_end_s;

  // Counter next state: restart a run, advance one pair, or open the next layer
  always_comb begin
    p_d         = p_q;
    z_d         = z_q;
    layer_d     = layer_q;
    mask_s      = pair_stride(layer_q) - 8'd1;
    group_end_s = (({1'b0, p_q} & mask_s) == mask_s);
    if (load_i) begin
      p_d     = 7'd0;
      z_d     = 7'd127;
      layer_d = 3'd0;
    end else if (step_i) begin
      // p wraps to 0 after pair 127, ready for the next pass
      p_d = p_q + 7'd1;
      if (group_end_s && (layer_q != SCALE_LAYER)) begin
        z_d = z_q - 7'd1;
      end else begin
        z_d = z_q;
      end
    end else if (next_layer_i) begin
      p_d     = 7'd0;
      layer_d = layer_q + 3'd1;
    end else begin
      p_d = p_q;
    end
  end

  // Issue fields for the next cycle; held while nothing is issued
  always_comb begin
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
    zeta_d   = zeta_q;
    mode_d   = MODE_BF;
    if (issue_next_i) begin
      addr_a_d = pair_addr_a(p_d, layer_d);
      addr_b_d = addr_a_d + pair_stride(layer_d);
      if (layer_d == SCALE_LAYER) begin
        zeta_d = 7'd0;
        mode_d = MODE_SCALE;
      end else begin
        zeta_d = z_d;
        mode_d = MODE_BF;
      end
    end else begin
      mode_d = MODE_BF;
    end
  end

  // Counter and issue-field registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_q      <= 7'd0;
      z_q      <= 7'd0;
      layer_q  <= 3'd0;
      addr_a_q <= 8'd0;
      addr_b_q <= 8'd0;
      zeta_q   <= 7'd0;
      mode_q   <= MODE_BF;
    end else begin
      p_q      <= p_d;
      z_q      <= z_d;
      layer_q  <= layer_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      zeta_q   <= zeta_d;
      mode_q   <= mode_d;
    end
  end

  assign p_o      = p_q;
  assign layer_o  = layer_q;
  assign addr_a_o = addr_a_q;
  assign addr_b_o = addr_b_q;
  assign zeta_o   = zeta_q;
  assign mode_o   = mode_q;

endmodule

// File: rtl/intt_sequencer.sv
// Inverse NTT sequencer: FSM over seven butterfly passes plus one scale
// pass, a drain gap between passes, and the write-back delay line that
// mirrors the butterfly unit latency.
module intt_sequencer
  import intt_pkg::*;
#(
  parameter int BF_LAT = 3,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic [ADDR_W-1:0] rd_addr_b,
  output logic [6:0]        zeta_idx,
  output logic              mode,
  output logic [2:0]        layer,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr_a,
  output logic [ADDR_W-1:0] wr_addr_b
);

  localparam logic [3:0] DRAIN_LAST = 4'(BF_LAT - 1);

  state_e     state_q, state_d;
  logic [3:0] drain_cnt_q, drain_cnt_d;
  logic       busy_q, done_q, rd_en_q;
  logic       load_s, step_s, next_layer_s;
  logic [6:0] p_s;

  logic [BF_LAT-1:0]             wb_vld_q;
  logic [BF_LAT-1:0][ADDR_W-1:0] wb_a_q;
  logic [BF_LAT-1:0][ADDR_W-1:0] wb_b_q;

  intt_addr_gen u_addr_gen (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (load_s),
    .step_i       (step_s),
    .next_layer_i (next_layer_s),
    .issue_next_i (state_d == ISSUE),
    .p_o          (p_s),
    .layer_o      (layer),
    .addr_a_o     (rd_addr_a),
    .addr_b_o     (rd_addr_b),
    .zeta_o       (zeta_idx),
    .mode_o       (mode)
  );

  // FSM next state and counter control; start is only honoured in IDLE
  always_comb begin
    state_d      = state_q;
    drain_cnt_d  = drain_cnt_q;
    load_s       = 1'b0;
    step_s       = 1'b0;
    next_layer_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          load_s  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        step_s = 1'b1;
        if (p_s == 7'd127) begin
          state_d     = DRAIN;
          drain_cnt_d = 4'd0;
        end else begin
          state_d = ISSUE;
        end
      end
      DRAIN: begin
        // wait out the butterfly latency so the next pass reads fresh data
        if (drain_cnt_q == DRAIN_LAST) begin
          drain_cnt_d = 4'd0;
          if (layer == SCALE_LAYER) begin
            state_d = DONE;
          end else begin
            state_d      = ISSUE;
            next_layer_s = 1'b1;
          end
        end else begin
          drain_cnt_d = drain_cnt_q + 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register and registered status strobes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      drain_cnt_q <= 4'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      busy_q      <= (state_d == ISSUE) || (state_d == DRAIN);
      done_q      <= (state_d == DONE);
      rd_en_q     <= (state_d == ISSUE);
    end
  end

  // Write-back delay line: replays each issue BF_LAT cycles later
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_vld_q <= '0;
      wb_a_q   <= '0;
      wb_b_q   <= '0;
    end else begin
      wb_vld_q[0] <= rd_en_q;
      wb_a_q[0]   <= rd_addr_a;
      wb_b_q[0]   <= rd_addr_b;
      for (int i = 1; i < BF_LAT; i++) begin
        wb_vld_q[i] <= wb_vld_q[i-1];
        wb_a_q[i]   <= wb_a_q[i-1];
        wb_b_q[i]   <= wb_b_q[i-1];
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_en     = rd_en_q;
  assign wr_en     = wb_vld_q[BF_LAT-1];
  assign wr_addr_a = wb_a_q[BF_LAT-1];
  assign wr_addr_b = wb_b_q[BF_LAT-1];

endmodule

// File: tb/tb_intt_sequencer.sv
// Directed bench for intt_sequencer: schedule, hazards, timing, restart
// rules and an end-to-end transform through a behavioural RAM/butterfly.
module tb_intt_sequencer;

  localparam int LAT = 3;
  localparam int QM  = 3329;
  localparam int FM  = 3303;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       busy, done, rd_en, mode, wr_en;
  logic [7:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [6:0] zeta_idx;
  logic [2:0] layer;

  intt_sequencer #(.BF_LAT(LAT), .ADDR_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .zeta_idx  (zeta_idx),
    .mode      (mode),
    .layer     (layer),
    .wr_en     (wr_en),
    .wr_addr_a (wr_addr_a),
    .wr_addr_b (wr_addr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk, n_bad;
  int zt [128];
  int ea [1024], eb [1024], ez [1024], em [1024], el [1024];
  int ram [256], vec [256], gold [256];
  int pend [256];
  int cov_cnt [8][256];
  int n_bf, n_sc;
  logic load_req;
  int fq_a [$];
  int fq_b [$];

  // single comparison point
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // behavioural coefficient RAM and fixed-latency butterfly/scale unit
  always @(posedge clk) begin
    if (!rst_n) begin
      fq_a.delete();
      fq_b.delete();
    end else begin
      if (load_req) begin
        for (int i = 0; i < 256; i++) ram[i] <= vec[i];
      end
      if (wr_en && fq_a.size() > 0) begin
        ram[wr_addr_a] <= fq_a.pop_front();
        ram[wr_addr_b] <= fq_b.pop_front();
      end
      if (rd_en) begin
        if (mode) begin
          fq_a.push_back((ram[rd_addr_a] * FM) % QM);
          fq_b.push_back((ram[rd_addr_b] * FM) % QM);
        end else begin
          fq_a.push_back((ram[rd_addr_a] + ram[rd_addr_b]) % QM);
          fq_b.push_back((zt[zeta_idx] * (ram[rd_addr_b] - ram[rd_addr_a] + QM)) % QM);
        end
      end
    end
  end

  // index into the expected issue list for cycle c, or -1 for no issue
  function automatic int issue_at(input int c);
    int pass, off;
    if (c < 1) return -1;
    pass = (c - 1) / (128 + LAT);
    off  = (c - 1) % (128 + LAT);
    if (pass < 8 && off < 128) return pass * 128 + off;
    return -1;
  endfunction

  function automatic logic [31:0] exp_word(input int i);
    return 32'((ea[i] << 19) | (eb[i] << 11) | (ez[i] << 4) | (em[i] << 3) | el[i]);
  endfunction

  // golden combinational inverse NTT on vec
  task automatic golden();
    int k, zz, t, u;
    for (int i = 0; i < 256; i++) gold[i] = vec[i];
    k = 127;
    for (int len = 2; len <= 128; len = len * 2) begin
      for (int s = 0; s < 256; s = s + 2 * len) begin
        zz = zt[k];
        k--;
        for (int j = s; j < s + len; j++) begin
          t = gold[j];
          u = gold[j+len];
          gold[j]     = (t + u) % QM;
          gold[j+len] = (zz * (u - t + QM)) % QM;
        end
      end
    end
    for (int i = 0; i < 256; i++) gold[i] = (gold[i] * FM) % QM;
  endtask

  // one transform: start in the current-next cycle, monitor every cycle
  task automatic run(input int spur_c, input bit pulse_done, input int abort_c);
    int ii, iw, last_c;
    for (int a = 0; a < 256; a++) begin
      pend[a] = 0;
      for (int l = 0; l < 8; l++) cov_cnt[l][a] = 0;
    end
    n_bf = 0;
    n_sc = 0;
    last_c = (abort_c > 0) ? abort_c + 40 : 8 * (128 + LAT) + 1;
    @(posedge clk);
    #1;
    start    = 1'b1;
    load_req = 1'b0;
    for (int c = 1; c <= last_c; c++) begin
      @(posedge clk);
      #1;
      start = (c == spur_c) || (pulse_done && c == 8 * (128 + LAT) + 1);
      if (abort_c > 0 && c == abort_c) rst_n = 1'b0;
      if (abort_c > 0 && c == abort_c + 5) rst_n = 1'b1;
      @(negedge clk);
      if (abort_c > 0 && c > abort_c) begin
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_rd_en", 32'(rd_en), 32'd0);
        chk("abort_wr_en", 32'(wr_en), 32'd0);
        chk("abort_fields", {5'd0, rd_addr_a, rd_addr_b, zeta_idx, mode, layer}, 32'd0);
      end else begin
        ii = issue_at(c);
        iw = issue_at(c - LAT);
        chk("busy", 32'(busy), 32'(c <= 8 * (128 + LAT)));
        chk("done", 32'(done), 32'(c == 8 * (128 + LAT) + 1));
        chk("rd_en", 32'(rd_en), 32'(ii >= 0));
        if (rd_en) begin
          if (ii >= 0) chk("issue", {5'd0, rd_addr_a, rd_addr_b, zeta_idx, mode, layer}, exp_word(ii));
          chk("raw", 32'(pend[rd_addr_a] + pend[rd_addr_b]), 32'd0);
          pend[rd_addr_a]++;
          pend[rd_addr_b]++;
          if (mode) n_sc++; else n_bf++;
          cov_cnt[layer][rd_addr_a]++;
          cov_cnt[layer][rd_addr_b]++;
        end
        chk("wr_en", 32'(wr_en), 32'(iw >= 0));
        if (wr_en) begin
          if (iw >= 0) chk("wr_addr", {16'd0, wr_addr_a, wr_addr_b}, 32'((ea[iw] << 8) | eb[iw]));
          if (pend[wr_addr_a] > 0) pend[wr_addr_a]--;
          if (pend[wr_addr_b] > 0) pend[wr_addr_b]--;
        end
      end
    end
  endtask

  // post-run totals, coverage and end-to-end result
  task automatic end_checks(input string tag);
    int bad_cov, bad_rng, left;
    bad_cov = 0;
    bad_rng = 0;
    left    = 0;
    chk({tag, "_n_bf"}, 32'(n_bf), 32'd896);
    chk({tag, "_n_sc"}, 32'(n_sc), 32'd128);
    for (int l = 0; l < 8; l++)
      for (int a = 0; a < 256; a++)
        if (cov_cnt[l][a] != 1) bad_cov++;
    chk({tag, "_coverage"}, 32'(bad_cov), 32'd0);
    for (int a = 0; a < 256; a++) left += pend[a];
    chk({tag, "_pending"}, 32'(left), 32'd0);
    golden();
    for (int i = 0; i < 256; i++) begin
      chk({tag, "_coef"}, 32'(ram[i]), 32'(gold[i]));
      if (ram[i] < 0 || ram[i] >= QM) bad_rng++;
    end
    chk({tag, "_range"}, 32'(bad_rng), 32'd0);
  endtask

  initial begin
    int idx, k, rv, pw;
    n_chk    = 0;
    n_bad    = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    load_req = 1'b0;

    // zeta ROM: 17^bitrev7(i) mod q
    for (int i = 0; i < 128; i++) begin
      rv = 0;
      for (int b = 0; b < 7; b++) if (((i >> b) & 1) != 0) rv = rv | (1 << (6 - b));
      pw = 1;
      for (int e = 0; e < rv; e++) pw = (pw * 17) % QM;
      zt[i] = pw;
    end

    // expected issue list from the reference loop nest
    idx = 0;
    k   = 127;
    for (int l = 0; l < 7; l++) begin
      for (int s = 0; s < 256; s = s + (4 << l)) begin
        for (int j = s; j < s + (2 << l); j++) begin
          ea[idx] = j; eb[idx] = j + (2 << l); ez[idx] = k; em[idx] = 0; el[idx] = l;
          idx++;
        end
        k--;
      end
    end
    for (int p = 0; p < 128; p++) begin
      ea[idx] = 2 * p; eb[idx] = 2 * p + 1; ez[idx] = 0; em[idx] = 1; el[idx] = 7;
      idx++;
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_fields", {5'd0, rd_addr_a, rd_addr_b, zeta_idx, mode, layer}, 32'd0);
    chk("rst_wr_addr", {16'd0, wr_addr_a, wr_addr_b}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // delta input
    for (int i = 0; i < 256; i++) vec[i] = (i == 0) ? 1 : 0;
    load_req = 1'b1;
    run(0, 1'b0, 0);
    end_checks("delta");

    // random input; start in cycle 200 and in the done cycle are ignored
    for (int i = 0; i < 256; i++) vec[i] = int'($urandom_range(0, QM - 1));
    load_req = 1'b1;
    run(200, 1'b1, 0);
    end_checks("rand1");

    // chained run: start one cycle after done
    for (int i = 0; i < 256; i++) vec[i] = int'($urandom_range(0, QM - 1));
    load_req = 1'b1;
    run(0, 1'b0, 0);
    end_checks("rand2");

    // reset in cycle 500..504 aborts the transform
    load_req = 1'b1;
    run(0, 1'b0, 500);

    // fresh run after the abort completes normally
    for (int i = 0; i < 256; i++) vec[i] = int'($urandom_range(0, QM - 1));
    load_req = 1'b1;
    run(0, 1'b0, 0);
    end_checks("rand3");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
